writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage of the RV32I core; producer side of the register-file write port consumed by the decode stage.
- Holds a one-entry MEM/WB register and waits for a data-cache response on loads.
- Sign/zero-extends and aligns load data, then selects the write-back value.
- Drives load_regfile/rd/regfilemux_out for exactly one cycle per retired instruction, plus a forwarding copy and a retire counter.

Parameters:
INSTRET_WIDTH, 64, width of retired-instruction counter (wraps modulo 2^INSTRET_WIDTH)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
mem_valid  input  1  memory stage presents an instruction
mem_ready  output  1  this stage accepts it (transfer = mem_valid & mem_ready at posedge)
in_rd  input  5  destination register
in_load_regfile  input  1  instruction writes rd
in_wb_sel  input  3  wb_sel_t write-back source select
in_funct3  input  3  load width/sign (rv32i load funct3)
in_alu_out  input  32  ALU result; bits [1:0] also the load byte offset
in_br_en  input  1  compare result (for slt/sltu)
in_u_imm  input  32  U-type immediate
in_pc  input  32  instruction PC
dmem_resp  input  1  data-cache read response strobe
dmem_rdata  input  32  data-cache read word
load_regfile  output  1  register-file write enable
rd  output  5  register-file write address
regfilemux_out  output  32  register-file write data
fwd_valid  output  1  MEM/WB entry holds a final result (for the forwarding unit)
fwd_rd  output  5  rd of that entry
fwd_data  output  32  that result
instret  output  INSTRET_WIDTH  retired-instruction count

Behaviour:
- Reset values:
  - state=EMPTY; entry cleared.
  - load_regfile=0, rd=0, regfilemux_out=0, fwd_valid=0, fwd_rd=0, fwd_data=0.
  - instret=0; mem_ready=1 after reset deasserts.
- Reset asserted mid-operation drops any held or pending entry immediately; a later dmem_resp is ignored.
- States: EMPTY, WAIT_MEM, COMMIT.
  - EMPTY: mem_ready=1. On transfer, latch all in_* fields. Go to WAIT_MEM if in_wb_sel==WB_LOAD, else to COMMIT with result computed from the latched fields.
  - WAIT_MEM: mem_ready=0. On dmem_resp, capture the aligned/extended load value and go to COMMIT. dmem_resp is sampled only in this state and ignored elsewhere.
  - COMMIT: load_regfile = latched load_regfile & (latched rd != 0); instret increments by 1 (every retired instruction, including rd=x0 and non-writing ones). mem_ready=1. A simultaneous transfer re-enters COMMIT or WAIT_MEM per the new entry; otherwise go to EMPTY.
- Throughput and latency:
  - Non-load instructions: back-to-back, one per cycle. Written in the cycle after transfer.
  - Loads: written in the cycle after dmem_resp. Minimum latency is 2 cycles after transfer.
- Outputs rd and regfilemux_out are registered values of the entry; valid only while load_regfile=1 but held stable otherwise.
- Result select:
  - WB_ALU = alu_out
  - WB_BR = {31'b0, br_en}
  - WB_UIMM = u_imm
  - WB_PC4 = pc + 4, modulo 2^32
  - WB_LOAD = load value
- Load format (off = alu_out[1:0]):
  - lb/lbu: byte at off.
  - lh/lhu: halfword at off[1]; off[0] is ignored, no misalignment trap.
  - lw: whole word, off ignored.
  - Sign-extend for lb/lh; zero-extend for lbu/lhu.
  - Undefined funct3 values (3, 6, 7) produce 0.
- Forwarding outputs:
  - fwd_valid = (state==COMMIT) & load_regfile.
  - fwd_rd and fwd_data mirror rd and regfilemux_out.
  - fwd_valid is never asserted while a load is in WAIT_MEM.
- Unused wb_sel encodings (5–7) commit 0.

Decomposition:
- rv32i_types package gains:
  - wb_sel_t enum (WB_ALU=0, WB_BR=1, WB_UIMM=2, WB_LOAD=3, WB_PC4=4)
  - load_funct3_t enum (lb=0, lh=1, lw=2, lbu=4, lhu=5)
  - wb_state_t enum
- One combinational sub-module, load_formatter (inputs funct3, offset, word; output 32-bit value), instantiated once.

Test Plan:
- Reset, then ALU op rd=5, alu_out=0x1234_5678, transfer at cycle 0 -> cycle 1: load_regfile=1, rd=5, regfilemux_out=0x12345678, instret=1.
- Three back-to-back ALU ops (rd=1,2,3), mem_valid held high -> mem_ready stays 1; load_regfile high three consecutive cycles with matching rd and data.
- lb, alu_out[1:0]=3, dmem_rdata=0x80FF_0000, dmem_resp 4 cycles after transfer -> mem_ready=0 during the wait; 0xFFFFFF80 written the cycle after resp. Same with lhu at offset 2 -> 0x000080FF.
- rd=0 ALU op, then WB_PC4 with pc=0xFFFF_FFFC -> no write for the first but instret increments; second writes 0x00000000.
- Stray dmem_resp in EMPTY -> no write. Reset asserted during WAIT_MEM, then dmem_resp -> outputs return to 0 asynchronously; no write occurs.
- WB_BR with br_en=1 -> 0x00000001. Load with funct3=3 -> 0x00000000.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I type definitions used by the write-back stage.
package rv32i_types;

    typedef enum logic [2:0] {
        WB_ALU  = 3'd0,
        WB_BR   = 3'd1,
        WB_UIMM = 3'd2,
        WB_LOAD = 3'd3,
        WB_PC4  = 3'd4
    } wb_sel_t;

    typedef enum logic [2:0] {
        lb  = 3'd0,
        lh  = 3'd1,
        lw  = 3'd2,
        lbu = 3'd4,
        lhu = 3'd5
    } load_funct3_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wb_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Write-back source mux; reserved selects (5-7) commit zero.
    function automatic logic [31:0] wb_select(
        input logic [2:0]  sel,
        input logic [31:0] alu_out,
        input logic        br_en,
        input logic [31:0] u_imm,
        input logic [31:0] pc,
        input logic [31:0] load_value
    );
        logic [31:0] res;
        res = 32'd0;
        case (sel)
            WB_ALU:  res = alu_out;
            WB_BR:   res = {31'd0, br_en};
            WB_UIMM: res = u_imm;
            WB_LOAD: res = load_value;
            WB_PC4:  res = pc + PC_STEP;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Aligns and sign/zero-extends a data-cache word for RV32I loads.
module load_formatter
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte picked by the full offset; halfword by offset[1] only (no misalignment trap).
    always_comb begin
        byte_sel = 8'd0;
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = 8'd0;
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Extension per load width; undefined funct3 encodings give zero.
    always_comb begin
        value = 32'd0;
        case (funct3)
            lb:      value = {{24{byte_sel[7]}}, byte_sel};
            lh:      value = {{16{half_sel[15]}}, half_sel};
            lw:      value = word;
            lbu:     value = {24'd0, byte_sel};
            lhu:     value = {16'd0, half_sel};
            default: value = 32'd0;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// RV32I write-back stage: one-entry MEM/WB register, load completion and
// register-file write port, with forwarding copy and retire counter.
//
// state    | meaning
// EMPTY    | no entry held, ready for a new instruction
// WAIT_MEM | load held, waiting for dmem_resp
// COMMIT   | entry retiring this cycle (write port driven)
module writeback_stage
    import rv32i_types::*;
#(
    parameter int INSTRET_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               in_rd,
    input  logic                     in_load_regfile,
    input  logic [2:0]               in_wb_sel,
    input  logic [2:0]               in_funct3,
    input  logic [31:0]              in_alu_out,
    input  logic                     in_br_en,
    input  logic [31:0]              in_u_imm,
    input  logic [31:0]              in_pc,
    input  logic                     dmem_resp,
    input  logic [31:0]              dmem_rdata,
    output logic                     load_regfile,
    output logic [4:0]               rd,
    output logic [31:0]              regfilemux_out,
    output logic                     fwd_valid,
    output logic [4:0]               fwd_rd,
    output logic [31:0]              fwd_data,
    output logic [INSTRET_WIDTH-1:0] instret
);

    wb_state_t state_q, state_d;

    logic [4:0]  pend_rd;
    logic        pend_load_regfile;
    logic [2:0]  pend_funct3;
    logic [1:0]  pend_offset;

    logic        out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [INSTRET_WIDTH-1:0] instret_q;

    logic        transfer;
    logic        latch_pend;
    logic        commit_now;
    logic        commit_we;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic [31:0] load_value;

    load_formatter u_load_formatter (
        .funct3 (pend_funct3),
        .offset (pend_offset),
        .word   (dmem_rdata),
        .value  (load_value)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake and the value retired on the next edge.
    always_comb begin
        state_d     = state_q;
        mem_ready   = (state_q != WAIT_MEM);
        transfer    = mem_valid & mem_ready;
        latch_pend  = 1'b0;
        commit_now  = 1'b0;
        commit_we   = 1'b0;
        commit_rd   = pend_rd;
        commit_data = load_value;
        case (state_q)
            EMPTY, COMMIT: begin
                if (transfer) begin
                    latch_pend = 1'b1;
                    if (in_wb_sel == WB_LOAD) begin
                        state_d = WAIT_MEM;
                    end else begin
                        state_d     = COMMIT;
                        commit_now  = 1'b1;
                        commit_we   = in_load_regfile & (in_rd != 5'd0);
                        commit_rd   = in_rd;
                        commit_data = wb_select(in_wb_sel, in_alu_out, in_br_en,
                                                in_u_imm, in_pc, 32'd0);
                    end
                end else begin
                    state_d = EMPTY;
                end
            end
            WAIT_MEM: begin
                if (dmem_resp) begin
                    state_d     = COMMIT;
                    commit_now  = 1'b1;
                    commit_we   = pend_load_regfile & (pend_rd != 5'd0);
                    commit_rd   = pend_rd;
                    commit_data = load_value;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Pending entry fields needed to finish a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_rd           <= 5'd0;
            pend_load_regfile <= 1'b0;
            pend_funct3       <= 3'd0;
            pend_offset       <= 2'd0;
        end else if (latch_pend) begin
            pend_rd           <= in_rd;
            pend_load_regfile <= in_load_regfile;
            pend_funct3       <= in_funct3;
            pend_offset       <= in_alu_out[1:0];
        end
    end

    // Write port registers; rd/data hold their last value between commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_we   <= 1'b0;
            out_rd   <= 5'd0;
            out_data <= 32'd0;
        end else if (commit_now) begin
            out_we   <= commit_we;
            out_rd   <= commit_rd;
            out_data <= commit_data;
        end else begin
            out_we   <= 1'b0;
        end
    end

    // Retire counter, visible during the commit cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (commit_now) begin
            instret_q <= instret_q + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign load_regfile   = out_we;
    assign rd             = out_rd;
    assign regfilemux_out = out_data;
    assign fwd_valid      = (state_q == COMMIT) & out_we;
    assign fwd_rd         = out_rd;
    assign fwd_data       = out_data;
    assign instret        = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed plus randomized bench for writeback_stage with a behavioural model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  in_rd;
    logic        in_load_regfile;
    logic [2:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_out;
    logic        in_br_en;
    logic [31:0] in_u_imm;
    logic [31:0] in_pc;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        load_regfile;
    logic [4:0]  rd;
    logic [31:0] regfilemux_out;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [63:0] instret;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_instret = 64'd0;

    writeback_stage #(.INSTRET_WIDTH(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .in_rd           (in_rd),
        .in_load_regfile (in_load_regfile),
        .in_wb_sel       (in_wb_sel),
        .in_funct3       (in_funct3),
        .in_alu_out      (in_alu_out),
        .in_br_en        (in_br_en),
        .in_u_imm        (in_u_imm),
        .in_pc           (in_pc),
        .dmem_resp       (dmem_resp),
        .dmem_rdata      (dmem_rdata),
        .load_regfile    (load_regfile),
        .rd              (rd),
        .regfilemux_out  (regfilemux_out),
        .fwd_valid       (fwd_valid),
        .fwd_rd          (fwd_rd),
        .fwd_data        (fwd_data),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load result from first principles: pick bytes by arithmetic shift, then extend.
    function automatic logic [31:0] ref_load(input int f3, input int off, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            0: return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            1: return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            2: return w;
            4: return b;
            5: return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input int sel, input logic [31:0] alu, input logic br,
                                               input logic [31:0] uimm, input logic [31:0] pc,
                                               input logic [31:0] ld);
        case (sel)
            0: return alu;
            1: return br ? 32'd1 : 32'd0;
            2: return uimm;
            3: return ld;
            4: return pc + 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    // One instruction through the stage; for loads the response arrives resp_delay cycles after transfer.
    task automatic send(input logic [4:0] r, input logic lr, input logic [2:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic br, input logic [31:0] uimm,
                        input logic [31:0] pc, input int resp_delay, input logic [31:0] rdata);
        logic [31:0] exp_data;
        logic        exp_we;
        chk("ready_before_transfer", {63'd0, mem_ready}, 64'd1);
        in_rd = r; in_load_regfile = lr; in_wb_sel = sel; in_funct3 = f3;
        in_alu_out = alu; in_br_en = br; in_u_imm = uimm; in_pc = pc;
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        in_rd = 5'($urandom); in_alu_out = $urandom; in_wb_sel = 3'($urandom);
        if (sel == 3'd3) begin
            for (int i = 1; i <= resp_delay; i++) begin
                chk("ready_low_in_wait", {63'd0, mem_ready}, 64'd0);
                chk("no_write_in_wait", {63'd0, load_regfile}, 64'd0);
                chk("no_fwd_in_wait", {63'd0, fwd_valid}, 64'd0);
                if (i < resp_delay) step();
            end
            dmem_resp = 1'b1;
            dmem_rdata = rdata;
            step();
            dmem_resp = 1'b0;
            dmem_rdata = $urandom;
            exp_data = ref_result(3, alu, br, uimm, pc, ref_load(int'(f3), int'(alu % 4), rdata));
        end else begin
            exp_data = ref_result(int'(sel), alu, br, uimm, pc, 32'd0);
        end
        exp_we = lr && (r != 5'd0);
        exp_instret = exp_instret + 64'd1;
        chk("load_regfile", {63'd0, load_regfile}, {63'd0, exp_we});
        chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, exp_we});
        chk("rd", {59'd0, rd}, {59'd0, r});
        chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, r});
        chk("regfilemux_out", {32'd0, regfilemux_out}, {32'd0, exp_data});
        chk("fwd_data", {32'd0, fwd_data}, {32'd0, exp_data});
        chk("instret", instret, exp_instret);
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b0; in_rd = 5'd0; in_load_regfile = 1'b0; in_wb_sel = 3'd0;
        in_funct3 = 3'd0; in_alu_out = 32'd0; in_br_en = 1'b0; in_u_imm = 32'd0; in_pc = 32'd0;
        dmem_resp = 1'b0; dmem_rdata = 32'd0;
        #12;
        chk("reset_load_regfile", {63'd0, load_regfile}, 64'd0);
        chk("reset_rd", {59'd0, rd}, 64'd0);
        chk("reset_data", {32'd0, regfilemux_out}, 64'd0);
        chk("reset_fwd_valid", {63'd0, fwd_valid}, 64'd0);
        chk("reset_fwd_data", {32'd0, fwd_data}, 64'd0);
        chk("reset_instret", instret, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        chk("ready_after_reset", {63'd0, mem_ready}, 64'd1);

        // ALU op, written the cycle after transfer.
        send(5'd5, 1'b1, 3'd0, 3'd0, 32'h1234_5678, 1'b0, 32'd0, 32'd0, 0, 32'd0);
        step();
        chk("idle_no_write", {63'd0, load_regfile}, 64'd0);
        chk("idle_rd_held", {59'd0, rd}, 64'd5);

        // Back-to-back ALU ops.
        send(5'd1, 1'b1, 3'd0, 3'd0, 32'hAAAA_0001, 1'b0, 32'd0, 32'd0, 0, 32'd0);
        send(5'd2, 1'b1, 3'd0, 3'd0, 32'hBBBB_0002, 1'b0, 32'd0, 32'd0, 0, 32'd0);
        send(5'd3, 1'b1, 3'd0, 3'd0, 32'hCCCC_0003, 1'b0, 32'd0, 32'd0, 0, 32'd0);

        // lb at offset 3 and lhu at offset 2, response four cycles after transfer.
        send(5'd7, 1'b1, 3'd3, 3'd0, 32'h0000_1003, 1'b0, 32'd0, 32'd0, 4, 32'h80FF_0000);
        chk("lb_value", {32'd0, regfilemux_out}, 64'hFFFF_FF80);
        send(5'd8, 1'b1, 3'd3, 3'd5, 32'h0000_1002, 1'b0, 32'd0, 32'd0, 4, 32'h80FF_0000);
        chk("lhu_value", {32'd0, regfilemux_out}, 64'h0000_80FF);
        send(5'd9, 1'b1, 3'd3, 3'd2, 32'h0000_1001, 1'b0, 32'd0, 32'd0, 1, 32'hDEAD_BEEF);

        // rd=x0 retires without writing; PC+4 wraps.
        send(5'd0, 1'b1, 3'd0, 3'd0, 32'h5555_5555, 1'b0, 32'd0, 32'd0, 0, 32'd0);
        send(5'd10, 1'b1, 3'd4, 3'd0, 32'd0, 1'b0, 32'd0, 32'hFFFF_FFFC, 0, 32'd0);
        chk("pc4_wrap", {32'd0, regfilemux_out}, 64'd0);

        // Stray response while empty.
        step();
        dmem_resp = 1'b1; dmem_rdata = 32'h1111_1111;
        step();
        dmem_resp = 1'b0;
        chk("stray_resp_no_write", {63'd0, load_regfile}, 64'd0);
        chk("stray_resp_instret", instret, exp_instret);

        // Branch compare result, undefined load funct3, reserved wb_sel.
        send(5'd11, 1'b1, 3'd1, 3'd0, 32'd0, 1'b1, 32'd0, 32'd0, 0, 32'd0);
        chk("br_value", {32'd0, regfilemux_out}, 64'd1);
        send(5'd12, 1'b1, 3'd3, 3'd3, 32'd0, 1'b0, 32'd0, 32'd0, 2, 32'hFFFF_FFFF);
        chk("funct3_3_value", {32'd0, regfilemux_out}, 64'd0);
        send(5'd13, 1'b1, 3'd6, 3'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'd0, 0, 32'd0);
        send(5'd14, 1'b1, 3'd2, 3'd0, 32'd0, 1'b0, 32'hABCD_E000, 32'd0, 0, 32'd0);

        // Reset in the middle of a load wait, then a late response.
        in_rd = 5'd15; in_load_regfile = 1'b1; in_wb_sel = 3'd3; in_funct3 = 3'd2; in_alu_out = 32'd0;
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        step();
        chk("wait_before_reset", {63'd0, mem_ready}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_rd", {59'd0, rd}, 64'd0);
        chk("async_reset_data", {32'd0, regfilemux_out}, 64'd0);
        chk("async_reset_instret", instret, 64'd0);
        chk("async_reset_ready", {63'd0, mem_ready}, 64'd1);
        step();
        rst = 1'b0;
        exp_instret = 64'd0;
        dmem_resp = 1'b1; dmem_rdata = 32'h7777_7777;
        step();
        dmem_resp = 1'b0;
        chk("late_resp_no_write", {63'd0, load_regfile}, 64'd0);
        chk("late_resp_instret", instret, 64'd0);
        chk("late_resp_ready", {63'd0, mem_ready}, 64'd1);

        // Randomized mix checked against the model.
        for (int n = 0; n < 60; n++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) s = 3'd3;
            send(5'($urandom), 1'($urandom), s, 3'($urandom), $urandom, 1'($urandom), $urandom,
                 $urandom, int'($urandom_range(1, 4)), $urandom);
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
